// File: rtl/display_message_arbiter.sv
// ---------------------------------------------------------------------------
// display_message_arbiter
//
// Purpose:
//   Shares one scrolling ASCII display among NUM_REQ message producers.
//   One requester is granted at a time. Its string is registered into
//   disp_buf and announced with a one-cycle disp_load pulse, together with
//   a one-cycle ack to the winner. The string is then held for
//   max(HOLD_CYCLES,1) cycles before the next request is considered.
//
// Ports:
//   clk        in   1                  system clock
//   reset      in   1                  synchronous, active-high
//   req        in   NUM_REQ            req[i] high: requester i has a message
//   req_buf    in   NUM_REQ*BUF_BITS   slice i = req_buf[i*BUF_BITS +: BUF_BITS]
//   ack        out  NUM_REQ            one-cycle pulse: requester's message loaded
//   disp_buf   out  BUF_BITS           string to the display, stable between loads
//   disp_load  out  1                  one-cycle pulse: display takes disp_buf
//   grant_id   out  IDW                requester currently on the display
//   busy       out  1                  high in LOAD and HOLD
//   state_dbg  out  2                  current FSM state (IDLE=0, LOAD=1, HOLD=2)
//
// Configuration:
//   ARB_FIXED_PRIORITY_EN  defined   -> lowest-index requester always wins,
//                                       no round-robin pointer exists.
//                          undefined -> round-robin starting after the last
//                                       winner (default).
//
// Handshake:
//   A requester raises req[i] with its req_buf slice and keeps both stable
//   until ack[i] pulses. Dropping req[i] earlier withdraws the message and no
//   ack follows. req is only sampled in IDLE; a requester keeping req high
//   after its ack is served again only after the others in round-robin order.
// ---------------------------------------------------------------------------
module display_message_arbiter #(
   parameter int          NUM_REQ     = 4,
   parameter int          BUF_BITS    = 80,
   parameter int          C           = 35,
   parameter int unsigned HOLD_CYCLES = 700_000_000,
   parameter int          IDW         = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*BUF_BITS-1:0] req_buf,
   output logic [NUM_REQ-1:0]          ack,
   output logic [BUF_BITS-1:0]         disp_buf,
   output logic                        disp_load,
   output logic [IDW-1:0]              grant_id,
   output logic                        busy,
   output logic [1:0]                  state_dbg
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   // A hold time of 0 behaves like 1 so HOLD always lasts at least a cycle.
   localparam int unsigned   HOLD_EFF  = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
   localparam logic [C-1:0]  HOLD_LAST = C'(HOLD_EFF - 1);

   logic [1:0]          state_q,    state_d;
   logic [C-1:0]        hold_cnt_q, hold_cnt_d;
   logic [BUF_BITS-1:0] disp_buf_q, disp_buf_d;
   logic [IDW-1:0]      grant_id_q, grant_id_d;
`ifndef ARB_FIXED_PRIORITY_EN
   logic [IDW-1:0]      rr_q,       rr_d;
`endif

   logic                found;
   logic [IDW-1:0]      winner;
   logic [BUF_BITS-1:0] win_buf;

   // Winner selection.
   always_comb begin
      found  = 1'b0;
      winner = '0;
`ifdef ARB_FIXED_PRIORITY_EN
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i]) begin
            found  = 1'b1;
            winner = IDW'(i);
         end
      end
`else
      // Scan starts one past the last winner and wraps, so the last winner
      // is considered last.
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (((int'(rr_q) + k) % NUM_REQ) == i)) begin
               found  = 1'b1;
               winner = IDW'(i);
            end
         end
      end
`endif
   end

   // Slice mux for the winning requester's string.
   always_comb begin
      win_buf = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == IDW'(i)) begin
            win_buf = req_buf[i*BUF_BITS +: BUF_BITS];
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      disp_buf_d = disp_buf_q;
      grant_id_d = grant_id_q;
`ifndef ARB_FIXED_PRIORITY_EN
      rr_d       = rr_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               disp_buf_d = win_buf;
               grant_id_d = winner;
`ifndef ARB_FIXED_PRIORITY_EN
               rr_d       = winner;
`endif
               state_d    = LOAD;
            end
         end
         LOAD: begin
            hold_cnt_d = '0;
            state_d    = HOLD;
         end
         HOLD: begin
            // HOLD_EFF < 2**C, so the counter never wraps before the exit.
            if (hold_cnt_q == HOLD_LAST) begin
               state_d = IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         disp_buf_q <= '0;
         grant_id_q <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
         rr_q       <= IDW'(NUM_REQ - 1);
`endif
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         disp_buf_q <= disp_buf_d;
         grant_id_q <= grant_id_d;
`ifndef ARB_FIXED_PRIORITY_EN
         rr_q       <= rr_d;
`endif
      end
   end

   // Outputs are decoded from registered state, so a reset edge clears them
   // immediately and ack/disp_load can only appear in LOAD.
   always_comb begin
      ack = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ack[i] = (state_q == LOAD) && (grant_id_q == IDW'(i));
      end
   end

   assign disp_load = (state_q == LOAD);
   assign busy      = (state_q != IDLE);
   assign disp_buf  = disp_buf_q;
   assign grant_id  = grant_id_q;
   assign state_dbg = state_q;

endmodule
